// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the PC fetch/execute sequencer
package pc_seq_pkg;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        TRAP  = 3'd3,
        HALT  = 3'd4
    } state_e;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_ALU    = 2'b10;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_ECALL     = 2'b01;
    localparam logic [1:0] CAUSE_FETCH_ERR = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'b11;

    // Jump targets come from the ALU and take precedence over a conditional branch.
    function automatic logic [1:0] sel_pc_src(input logic jump, input logic branch);
        if (jump) begin
            return PC_SRC_ALU;
        end else if (branch) begin
            return PC_SRC_BRANCH;
        end
        return PC_SRC_SEQ;
    endfunction

endpackage

// File: rtl/pc_seq_counter.sv
// rtl/pc_seq_counter.sv - saturating, clearable up-counter for boot and fetch-wait counts
module pc_seq_counter #(
    parameter int          W   = 4,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over increment; the count parks at MAX instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register, cleared by the asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/execute controller driving program_counter and the imem handshake
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               XLEN        = 64,
    parameter int               BOOT_CYCLES = 2,
    parameter int               TIMEOUT     = 15,
    parameter logic [XLEN-1:0]  TRAP_VECTOR = 'h100
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic            imem_err,
    input  logic            branch,
    input  logic            jump,
    input  logic            system,
    input  logic            halt_req,
    input  logic            resume,
    input  logic [XLEN-1:0] pc_current,
    output logic [1:0]      pc_src,
    output logic            pc_write,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            retire,
    output logic [63:0]     instret,
    output logic            trap_valid,
    output logic [1:0]      trap_cause,
    output logic [XLEN-1:0] epc,
    output logic [2:0]      state
);

    localparam int              BOOT_W    = $clog2(BOOT_CYCLES + 1);
    localparam int              WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_e            state_q;
    state_e            state_d;
    logic [63:0]       instret_q;
    logic [63:0]       instret_d;
    logic [XLEN-1:0]   epc_q;
    logic [XLEN-1:0]   epc_d;
    logic [1:0]        cause_q;
    logic [1:0]        cause_d;

    logic [BOOT_W-1:0] boot_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_boot;
    logic              in_fetch;
    logic              boot_done;
    logic              fetch_timeout;
    logic              wait_clr;

    assign in_boot       = (state_q == BOOT);
    assign in_fetch      = (state_q == FETCH);
    assign boot_done     = in_boot && (boot_cnt == BOOT_LAST);
    // A same-cycle ack beats the timeout.
    assign fetch_timeout = in_fetch && !imem_ack && (wait_cnt == WAIT_LAST);
    // The wait count restarts for every fetch, whichever way the previous one ended.
    assign wait_clr      = !in_fetch || imem_ack || fetch_timeout;

    pc_seq_counter #(
        .W   (BOOT_W),
        .MAX (BOOT_LAST)
    ) u_boot_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (!in_boot),
        .en    (in_boot),
        .count (boot_cnt)
    );

    pc_seq_counter #(
        .W   (WAIT_W),
        .MAX (WAIT_LAST)
    ) u_wait_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (wait_clr),
        .en    (in_fetch),
        .count (wait_cnt)
    );

    // Next-state logic plus the outputs decoded from the current state and decode flags.
    always_comb begin
        state_d     = state_q;
        instret_d   = instret_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        imem_req    = 1'b0;
        pc_src      = PC_SRC_SEQ;
        pc_write    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        retire      = 1'b0;
        trap_valid  = 1'b0;
        case (state_q)
            BOOT: begin
                if (boot_done) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (imem_err) begin
                        state_d = TRAP;
                        cause_d = CAUSE_FETCH_ERR;
                        epc_d   = pc_current;
                    end else begin
                        state_d = EXEC;
                    end
                end else if (fetch_timeout) begin
                    state_d = TRAP;
                    cause_d = CAUSE_TIMEOUT;
                    epc_d   = pc_current;
                end
            end
            EXEC: begin
                if (system) begin
                    state_d = TRAP;
                    cause_d = CAUSE_ECALL;
                    epc_d   = pc_current;
                end else begin
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    pc_src    = sel_pc_src(jump, branch);
                    instret_d = instret_q + 64'd1;
                    state_d   = halt_req ? HALT : FETCH;
                end
            end
            TRAP: begin
                pc_write    = 1'b1;
                pc_src      = PC_SRC_ALU;
                redirect    = 1'b1;
                redirect_pc = TRAP_VECTOR;
                trap_valid  = 1'b1;
                state_d     = halt_req ? HALT : FETCH;
            end
            HALT: begin
                if (resume && !halt_req) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and architectural registers; reset forces BOOT so every decoded output drops at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= BOOT;
            instret_q <= '0;
            epc_q     <= '0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
        end
    end

    assign instret    = instret_q;
    assign epc        = epc_q;
    assign trap_cause = cause_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with a behavioural instruction model
module tb_pc_sequencer;

    localparam int          XLEN        = 64;
    localparam int          BOOT_CYCLES = 2;
    localparam int          TIMEOUT     = 15;
    localparam logic [63:0] TRAP_VECTOR = 64'h100;

    logic            clock;
    logic            reset;
    logic            imem_req;
    logic            imem_ack;
    logic            imem_err;
    logic            branch;
    logic            jump;
    logic            system;
    logic            halt_req;
    logic            resume;
    logic [XLEN-1:0] pc_current;
    logic [1:0]      pc_src;
    logic            pc_write;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            retire;
    logic [63:0]     instret;
    logic            trap_valid;
    logic [1:0]      trap_cause;
    logic [XLEN-1:0] epc;
    logic [2:0]      state;

    pc_sequencer #(
        .XLEN        (XLEN),
        .BOOT_CYCLES (BOOT_CYCLES),
        .TIMEOUT     (TIMEOUT),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_err    (imem_err),
        .branch      (branch),
        .jump        (jump),
        .system      (system),
        .halt_req    (halt_req),
        .resume      (resume),
        .pc_current  (pc_current),
        .pc_src      (pc_src),
        .pc_write    (pc_write),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .retire      (retire),
        .instret     (instret),
        .trap_valid  (trap_valid),
        .trap_cause  (trap_cause),
        .epc         (epc),
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  src;
        bit          trap;
        logic [1:0]  cause;
        logic [63:0] epc;
        logic [63:0] instret;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [63:0] pc_model;
    logic [63:0] m_instret;
    logic [1:0]  m_cause;
    logic [63:0] m_epc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] src, input bit trap);
        exp_t e;
        e.src     = src;
        e.trap    = trap;
        e.cause   = m_cause;
        e.epc     = m_epc;
        e.instret = m_instret;
        exp_q.push_back(e);
    endtask

    // Monitor: every PC update must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset === 1'b1 && pc_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pc_write: got pc_src %0h with empty queue", pc_src);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pc_src", 64'(pc_src), 64'(e.src));
                chk("retire", 64'(retire), 64'(!e.trap));
                chk("trap_valid", 64'(trap_valid), 64'(e.trap));
                chk("redirect", 64'(redirect), 64'(e.trap));
                chk("redirect_pc", redirect_pc, e.trap ? TRAP_VECTOR : 64'h0);
                chk("trap_cause", 64'(trap_cause), 64'(e.cause));
                chk("epc", epc, e.epc);
                chk("instret", instret, e.instret);
            end
        end
    end

    // One instruction: d = ack delay in FETCH cycles (>= TIMEOUT means never), then decode/halt choices.
    task automatic run_instr(input int d, input bit err, input bit j, input bit b,
                             input bit s, input bit h);
        bit          acked;
        logic [63:0] next_pc;
        acked = 1'b0;
        for (int k = 0; k < TIMEOUT; k++) begin
            chk("fetch_imem_req", 64'(imem_req), 64'd1);
            branch = 1'($urandom);
            jump   = 1'($urandom);
            system = 1'($urandom);
            if (k == d) begin
                imem_ack = 1'b1;
                imem_err = err;
                acked    = 1'b1;
            end else begin
                imem_ack = 1'b0;
                imem_err = 1'($urandom);
            end
            if (k == d || k == TIMEOUT - 1) break;
            step();
        end
        step();
        imem_ack = 1'($urandom);
        imem_err = 1'($urandom);
        if (acked && !err) begin
            jump     = j;
            branch   = b;
            system   = s;
            halt_req = h;
            if (s) begin
                m_cause = 2'b01;
                m_epc   = pc_model;
                push_exp(2'b10, 1'b1);
                step();
                next_pc = TRAP_VECTOR;
            end else begin
                push_exp(j ? 2'b10 : (b ? 2'b01 : 2'b00), 1'b0);
                m_instret = m_instret + 64'd1;
                if (j) next_pc = {$urandom, $urandom} & ~64'h3;
                else if (b) next_pc = pc_model + 64'd8;
                else next_pc = pc_model + 64'd4;
            end
        end else begin
            halt_req = h;
            m_cause  = acked ? 2'b10 : 2'b11;
            m_epc    = pc_model;
            push_exp(2'b10, 1'b1);
            next_pc  = TRAP_VECTOR;
        end
        step();
        pc_model   = next_pc;
        pc_current = next_pc;
        jump       = 1'b0;
        branch     = 1'b0;
        system     = 1'b0;
        if (h) begin
            chk("halt_state", 64'(state), 64'd4);
            chk("halt_imem_req", 64'(imem_req), 64'd0);
            resume = 1'b1;
            step();
            resume = 1'b0;
            chk("halt_resume_ignored", 64'(state), 64'd4);
            halt_req = 1'b0;
            step();
            chk("halt_hold", 64'(state), 64'd4);
            resume = 1'b1;
            step();
            resume = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        imem_ack   = 1'b0;
        imem_err   = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        system     = 1'b0;
        halt_req   = 1'b0;
        resume     = 1'b0;
        pc_model   = 64'h0;
        pc_current = 64'h0;
        m_instret  = 64'h0;
        m_cause    = 2'b00;
        m_epc      = 64'h0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_pc_src", 64'(pc_src), 64'd0);
        chk("rst_pc_write", 64'(pc_write), 64'd0);
        chk("rst_redirect", 64'(redirect), 64'd0);
        chk("rst_redirect_pc", redirect_pc, 64'd0);
        chk("rst_retire", 64'(retire), 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_trap_valid", 64'(trap_valid), 64'd0);
        chk("rst_trap_cause", 64'(trap_cause), 64'd0);
        chk("rst_epc", epc, 64'd0);
        chk("rst_state", 64'(state), 64'd0);

        reset = 1'b1;
        for (int c = 1; c <= BOOT_CYCLES; c++) begin
            step();
            chk("boot_imem_req", 64'(imem_req), (c == BOOT_CYCLES) ? 64'd1 : 64'd0);
        end

        // Three straight-line instructions, then the boundary and priority cases.
        repeat (3) run_instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("instret_after_3", instret, 64'd3);
        run_instr(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_instr(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_instr(0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_instr(TIMEOUT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(TIMEOUT - 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_instr(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 60; n++) begin
            int r;
            int d;
            r = $urandom_range(0, 9);
            if (r < 6) d = $urandom_range(0, 2);
            else if (r < 8) d = $urandom_range(3, TIMEOUT - 1);
            else if (r == 8) d = TIMEOUT;
            else d = TIMEOUT - 1;
            run_instr(d, ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
        end

        chk("instret_final", instret, m_instret);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a fetch must drop the request without waiting for a clock.
        chk("pre_reset_imem_req", 64'(imem_req), 64'd1);
        reset = 1'b0;
        #1;
        chk("midrst_imem_req", 64'(imem_req), 64'd0);
        chk("midrst_pc_write", 64'(pc_write), 64'd0);
        chk("midrst_state", 64'(state), 64'd0);
        chk("midrst_instret", instret, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
